// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared widths, buffer depth, FSM state type and a
// saturating-increment helper for the fetch sequencer.
package fetch_ctrl_pkg;

  localparam int BUS_ADDRESS     = 6;   // PC / ROM address width (64 lines)
  localparam int BUS_DATA        = 32;  // instruction width
  localparam int FETCH_BUF_DEPTH = 2;   // skid buffer entries
  localparam int PERF_CNT_W      = 16;  // performance counter width

  // Occupancy counter must represent 0..FETCH_BUF_DEPTH inclusive.
  localparam int CNT_W = $clog2(FETCH_BUF_DEPTH + 1);
  localparam int PTR_W = $clog2(FETCH_BUF_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: program_counter / ROM side and decode-side handshake of the
// fetch stage. The master modport is the fetch controller.
//
// Decode handshake: instr_valid/instr_out/instr_pc are offered by the master;
// one instruction transfers on every rising edge where instr_valid and
// dec_ready are both 1. While instr_valid is 1 and dec_ready is 0, the head
// (instr_out, instr_pc) is held stable. instr_valid never depends on dec_ready.
interface fetch_ctrl_if;
  import fetch_ctrl_pkg::*;

  // program_counter / instruction ROM side
  logic                   pc_ena;
  logic                   pc_jmp;
  logic [BUS_ADDRESS-1:0] pc_jmp_in;
  logic [BUS_ADDRESS-1:0] pc_in;
  logic [BUS_DATA-1:0]    mem_data;

  // decode side
  logic                   instr_valid;
  logic [BUS_DATA-1:0]    instr_out;
  logic [BUS_ADDRESS-1:0] instr_pc;
  logic                   dec_ready;

  modport master (
    output pc_ena, pc_jmp, pc_jmp_in, instr_valid, instr_out, instr_pc,
    input  pc_in, mem_data, dec_ready
  );

  modport slave (
    input  pc_ena, pc_jmp, pc_jmp_in, instr_valid, instr_out, instr_pc,
    output pc_in, mem_data, dec_ready
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: FETCH_BUF_DEPTH-entry FIFO of {pc, instr}. The head is read
// straight from storage so the decode outputs are register-driven. Flush
// empties the FIFO and wins over a simultaneous push or pop.
module fetch_skid_buf
  import fetch_ctrl_pkg::*;
#(
  parameter int AW = BUS_ADDRESS,
  parameter int DW = BUS_DATA
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [AW-1:0]    i_pc,
  input  logic [DW-1:0]    i_instr,
  output logic [CNT_W-1:0] o_count,
  output logic [AW-1:0]    o_head_pc,
  output logic [DW-1:0]    o_head_instr
);

  logic [AW-1:0]    r_pc    [FETCH_BUF_DEPTH];
  logic [DW-1:0]    r_instr [FETCH_BUF_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // Guard against underflow/overflow; a full buffer may accept a push only
  // when the head leaves in the same cycle.
  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != CNT_W'(FETCH_BUF_DEPTH)) || w_pop);

  // Storage, pointers and occupancy; reset also clears storage so the head
  // outputs read zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FETCH_BUF_DEPTH; i++) begin
        r_pc[i]    <= '0;
        r_instr[i] <= '0;
      end
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_pc[r_wr_ptr]    <= i_pc;
        r_instr[r_wr_ptr] <= i_instr;
        r_wr_ptr          <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count      = r_count;
  assign o_head_pc    = r_pc[r_rd_ptr];
  assign o_head_instr = r_instr[r_rd_ptr];

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer. Drives program_counter enable/jump,
// captures the ROM word for the current PC into a 2-entry skid buffer and
// offers the buffer head to decode. Issue depends only on registered state
// and occupancy, so decode back-pressure never reaches pc_ena combinationally.
// An execute redirect (jmp_req) flushes the buffer and loads the PC in the
// same cycle, costing one bubble.
// Optional build macro: FETCH_CTRL_PERF_EN enables the stall_cycles and
// flush_count performance counters; without it both read constant 0.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   halt_req,
  input  logic                   jmp_req,
  input  logic [BUS_ADDRESS-1:0] jmp_addr,
  fetch_ctrl_if.master           bus,
  output logic                   busy,
  output logic [PERF_CNT_W-1:0]  stall_cycles,
  output logic [PERF_CNT_W-1:0]  flush_count,
  output fetch_state_t           o_dbg_state
);

  fetch_state_t           r_state;
  logic [CNT_W-1:0]       w_count;
  logic [BUS_ADDRESS-1:0] w_head_pc;
  logic [BUS_DATA-1:0]    w_head_instr;
  logic                   w_redirect;
  logic                   w_issue;
  logic                   w_valid;
  logic                   w_pop;
  logic                   w_drain_done;

  // Reset masks everything, including a redirect in the same cycle.
  assign w_redirect = jmp_req && !rst;

  // Issue only from RUN with room in the buffer; halt_req suppresses the
  // issue in the cycle it arrives, and a redirect discards the ROM word.
  assign w_issue = !rst && !jmp_req && !halt_req && (r_state == RUN) &&
                   (w_count < CNT_W'(FETCH_BUF_DEPTH));

  assign w_valid = (w_count != '0) && !w_redirect && !rst;
  assign w_pop   = w_valid && bus.dec_ready;

  // DRAIN never pushes, so the buffer empties when the last entry pops.
  assign w_drain_done = (w_count == '0) ||
                        ((w_count == CNT_W'(1)) && w_pop);

  assign bus.pc_ena      = w_redirect || w_issue;
  assign bus.pc_jmp      = w_redirect;
  assign bus.pc_jmp_in   = w_redirect ? jmp_addr : '0;
  assign bus.instr_valid = w_valid;
  assign bus.instr_out   = w_head_instr;
  assign bus.instr_pc    = w_head_pc;

  assign busy        = (r_state != IDLE);
  assign o_dbg_state = r_state;

  fetch_skid_buf #(
    .AW (BUS_ADDRESS),
    .DW (BUS_DATA)
  ) u_buf (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_issue),
    .i_pop        (w_pop),
    .i_flush      (w_redirect),
    .i_pc         (bus.pc_in),
    .i_instr      (bus.mem_data),
    .o_count      (w_count),
    .o_head_pc    (w_head_pc),
    .o_head_instr (w_head_instr)
  );

  // Sequencer FSM; a redirect outranks start/halt and ends a drain early.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else if (jmp_req) begin
      if (r_state == DRAIN) r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (start)        r_state <= RUN;
        RUN:     if (halt_req)     r_state <= DRAIN;
        DRAIN:   if (w_drain_done) r_state <= IDLE;
        default:                   r_state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  logic [PERF_CNT_W-1:0] r_stall_cycles;
  logic [PERF_CNT_W-1:0] r_flush_count;

  // Saturating counters: decode stall cycles and accepted redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (w_valid && !bus.dec_ready) r_stall_cycles <= sat_inc(r_stall_cycles);
      if (w_redirect)                r_flush_count  <= sat_inc(r_flush_count);
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencer for the fetch stage: drives `ena`/`jmp`/`jmp_in` of `program_counter` and captures the word returned by `instructions` into a 2-entry buffer. It presents instructions to decode with a valid/ready handshake. It absorbs decode back-pressure without a combinational path from `dec_ready` to `pc_ena`, and applies execute-stage redirects with a one-cycle bubble. It sits between `program_counter`/`instructions` and the decode stage, replacing the constant `ena=1`/`rst=0` tie-offs.

## Interface
- `bus_address`, 6, PC/ROM address width (64 lines)
- `bus_data`, 32, instruction width
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: pulse; begin fetching from current PC
- `halt_req` in 1: pulse; stop issuing, drain buffer
- `jmp_req` in 1: redirect from execute, single cycle
- `jmp_addr` in bus_address: redirect target
- `pc_in` in bus_address: current `program_counter` value
- `mem_data` in bus_data: ROM word for `pc_in`, valid in the same cycle (ROM samples on `~clk`)
- `pc_ena` out 1: to `program_counter.ena`
- `pc_jmp` out 1: to `program_counter.jmp`
- `pc_jmp_in` out bus_address: to `program_counter.jmp_in`
- `instr_valid` out 1: buffer head valid
- `instr_out` out bus_data: head instruction
- `instr_pc` out bus_address: address of head instruction
- `dec_ready` in 1: decode accepts head
- `busy` out 1: state != IDLE
- `stall_cycles` out 16: perf counter (see Configuration)
- `flush_count` out 16: perf counter (see Configuration)

## Operation
- States (`fetch_state_t`): IDLE, RUN, DRAIN.
- IDLE:
  - No issue.
  - `start` -> RUN.
  - `halt_req` is ignored.
- RUN: issue when buffer count < 2.
  - Issue means `pc_ena=1`. The pair {`mem_data`, `pc_in`} is pushed into the buffer at the same edge.
  - `halt_req` -> DRAIN; no issue in that cycle.
- DRAIN:
  - No issue; buffer keeps delivering.
  - -> IDLE at the edge where the count becomes 0.
- Pop: `instr_valid && dec_ready`.
- Push and pop in the same cycle are allowed; the count is unchanged.
- `pc_ena` in RUN depends only on the registered count and state, never on `dec_ready`.
- Redirect (`jmp_req`=1), in any state:
  - Highest priority over push, pop, `start` and `halt_req`.
  - Combinationally drives `pc_jmp=1`, `pc_ena=1`, `pc_jmp_in=jmp_addr`.
  - The current `mem_data` is discarded.
  - The buffer is flushed (count becomes 0).
  - `instr_valid` is forced 0 that cycle, so no transfer to decode occurs.
  - State: RUN stays RUN. IDLE stays IDLE, so a redirect sets the start address. DRAIN -> IDLE.
- Outside redirect cycles, `pc_jmp=0` and `pc_jmp_in=0`.
- Buffer is FIFO-ordered. The head is registered: `instr_out`/`instr_pc` come from storage, not from `mem_data`.

## Timing
- Reset values:
  - state IDLE, buffer empty.
  - `pc_ena`, `pc_jmp`, `pc_jmp_in`, `instr_valid`, `instr_out`, `instr_pc`, `busy` = 0.
  - Counters = 0.
- `rst` overrides all inputs, including `jmp_req`, and clears mid-operation without emitting a transfer.
- Start latency:
  - `start` at edge E: first issue in cycle E+1.
  - `instr_valid=1` in cycle E+2 with `instr_pc=pc_in` as sampled at E+1.
- With `dec_ready` held 1: one instruction per cycle, no bubbles.
- Redirect at cycle R:
  - PC equals `jmp_addr` at R+1.
  - Target is pushed at R+1.
  - Target is valid at the head at R+2.
  - Exactly one bubble.
- `dec_ready=0` with the buffer full: `pc_ena=0`. `instr_out` and `instr_pc` stay stable until popped.
- PC wrap 63 -> 0 is handled by `program_counter`. The controller treats addresses opaquely.

## Configuration
- `FETCH_CTRL_PERF_EN` defined:
  - `stall_cycles` counts cycles with `instr_valid && !dec_ready`.
  - `flush_count` counts accepted `jmp_req`.
  - Both are 16-bit, saturate at 0xFFFF, and are cleared by `rst`.
- Not defined: both ports are constant 0 and no counter registers are synthesized.

## Structure
- `fetch_ctrl_pkg` contains:
  - `fetch_state_t` enum.
  - `FETCH_BUF_DEPTH = 2`.
  - `PERF_CNT_W = 16`.
- Sub-module `fetch_skid_buf`:
  - Parameterized 2-entry FIFO of {pc, instr}.
  - Ports: push, pop, flush, count, head outputs.
  - Synchronous `rst`; flush has priority over push.

## Test plan
- Reset, then `start`, ROM word i = 0x1000_0000+i, `dec_ready=1` -> `instr_pc` 0,1,2,3... on consecutive cycles from start+2, with `instr_out` 0x1000_0000, 0x1000_0001, ...
- `dec_ready=0` for 5 cycles mid-stream -> `pc_ena` drops after 2 pushes, head held constant, no instruction lost or duplicated after release. Perf build: `stall_cycles=5`.
- `jmp_req` with `jmp_addr=2` while streaming at PC 7 -> one bubble, then `instr_pc` 2,3,4... Addresses 7/8 never reach decode. Perf build: `flush_count=1`.
- `jmp_req` (addr 1) coincident with `dec_ready=1` and a full buffer -> no transfer that cycle, buffer empty next cycle, `instr_pc=1` two cycles later.
- `halt_req` with 2 buffered and `dec_ready=1` -> no further `pc_ena`, 2 pops, IDLE, `busy=0`. A following `start` resumes at the next unfetched PC.
- `rst` asserted during DRAIN with a full buffer -> next cycle all outputs 0, state IDLE.
